// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Purpose  : Instruction-memory slave for the fetch stage. Accepts one fetch
//            at a time on a valid/ready request channel, waits LATENCY
//            cycles, then returns the word (or a NOP plus fault flag for a
//            misaligned or out-of-range address) on a valid/ready response
//            channel. A flush aborts whatever is outstanding. The program is
//            preloaded through a simple write port.
// Ports    : clk, rst_n (async, active-low)
//            req_valid/req_ready/req_addr        - fetch request channel
//            flush                               - branch-redirect abort
//            resp_valid/resp_ready/resp_instr/
//            resp_addr/resp_fault                - fetch response channel
//            load_en/load_addr/load_data         - program-load write port
// Revision : 1.0 - initial release
// ============================================================================
module imem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [63:0]              req_addr,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_instr,
  output logic [63:0]              resp_addr,
  output logic                     resp_fault,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [63:0] DEPTH_W  = 64'(DEPTH);
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_instr_q, resp_instr_d;
  logic [63:0]   resp_addr_q, resp_addr_d;
  logic          resp_fault_q, resp_fault_d;

  logic [31:0]   mem_q [DEPTH];

  logic          accept;
  logic [63:0]   offset;
  logic [AW-1:0] lookup_idx;
  logic          lookup_fault;

  // A new request can only be taken when nothing is outstanding, or when the
  // current response is being consumed this very cycle (back-to-back).
  assign req_ready = !flush && ((state_q == S_IDLE) ||
                                ((state_q == S_RESP) && resp_ready));
  assign accept    = req_valid && req_ready;

  // Lookup works on the captured address, not on req_addr, so the request
  // bus is free to change while the access is in flight. The unsigned
  // subtract wraps for addresses below BASE_ADDR, hence the explicit compare.
  assign offset       = resp_addr_q - BASE_ADDR;
  assign lookup_idx   = offset[AW+1:2];
  assign lookup_fault = (resp_addr_q[1:0] != 2'b00) ||
                        (resp_addr_q < BASE_ADDR)    ||
                        ((offset >> 2) >= DEPTH_W);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_addr_d  = resp_addr_q;
    resp_fault_d = resp_fault_q;

    if (flush) begin
      // Redirect wins over everything: drop the outstanding access outright.
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
      cnt_d        = 4'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_d     = S_WAIT;
            cnt_d       = CNT_INIT;
            resp_addr_d = req_addr;
          end
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_fault_d = lookup_fault;
            resp_instr_d = lookup_fault ? NOP : mem_q[lookup_idx];
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_d = 1'b0;
            state_d      = S_IDLE;
            if (accept) begin
              state_d     = S_WAIT;
              cnt_d       = CNT_INIT;
              resp_addr_d = req_addr;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= 32'h0;
      resp_addr_q  <= 64'h0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_addr_q  <= resp_addr_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  // Program storage is intentionally not reset. A write on the same edge as
  // a lookup is seen only by later accesses (read uses pre-edge contents).
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_addr  = resp_addr_q;
  assign resp_fault = resp_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_responder
// Purpose  : Bench for imem_responder. Two instances share one stimulus
//            stream: u_dut0 (LATENCY=1, BASE_ADDR=0) and u_dut1 (LATENCY=3,
//            BASE_ADDR=0x100). A transaction-level model predicts every
//            output each cycle; directed sequences add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

  localparam int NI    = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        flush;
  logic        resp_ready;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [31:0] load_data;

  logic        req_ready_o  [NI];
  logic        resp_valid_o [NI];
  logic [31:0] resp_instr_o [NI];
  logic [63:0] resp_addr_o  [NI];
  logic        resp_fault_o [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(64'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_o[0]), .req_addr(req_addr),
    .flush(flush),
    .resp_valid(resp_valid_o[0]), .resp_ready(resp_ready),
    .resp_instr(resp_instr_o[0]), .resp_addr(resp_addr_o[0]),
    .resp_fault(resp_fault_o[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_responder #(.DEPTH(DEPTH), .LATENCY(3), .BASE_ADDR(64'h100)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready_o[1]), .req_addr(req_addr),
    .flush(flush),
    .resp_valid(resp_valid_o[1]), .resp_ready(resp_ready),
    .resp_instr(resp_instr_o[1]), .resp_addr(resp_addr_o[1]),
    .resp_fault(resp_fault_o[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  // ---------------------------------------------------------------- model
  logic [31:0] mmem [DEPTH];
  bit          m_pend  [NI];
  logic [63:0] m_paddr [NI];
  longint      m_due   [NI];
  bit          m_rv    [NI];
  logic [63:0] m_raddr [NI];
  logic [31:0] m_rinstr[NI];
  bit          m_rfault[NI];
  longint      cyc = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [63:0] base_of(input int i);
    return (i == 0) ? 64'h0 : 64'h100;
  endfunction

  function automatic bit exp_ready(input int i);
    return !flush && (!(m_pend[i] || m_rv[i]) || (m_rv[i] && resp_ready));
  endfunction

  task automatic lookup(input logic [63:0] a, input logic [63:0] base,
                        output logic [31:0] ins, output bit f);
    logic [63:0] idx;
    idx = (a - base) >> 2;
    f   = (a[1:0] != 2'b00) || (a < base) || (idx >= 64'(DEPTH));
    ins = f ? 32'h0000_0013 : mmem[idx[9:0]];
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_pend[i] = 0; m_rv[i] = 0; m_due[i] = 0;
      m_paddr[i] = '0; m_raddr[i] = '0; m_rinstr[i] = '0; m_rfault[i] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          m_pend[i] = 0;
          m_rv[i]   = 0;
        end else begin
          bit acc;
          acc = req_valid && exp_ready(i);
          if (flush) begin
            m_pend[i] = 0;
            m_rv[i]   = 0;
          end else begin
            if (m_rv[i] && resp_ready) m_rv[i] = 0;
            if (m_pend[i] && cyc == m_due[i]) begin
              lookup(m_paddr[i], base_of(i), m_rinstr[i], m_rfault[i]);
              m_raddr[i] = m_paddr[i];
              m_rv[i]    = 1;
              m_pend[i]  = 0;
            end
            if (acc) begin
              m_pend[i]  = 1;
              m_paddr[i] = req_addr;
              m_due[i]   = cyc + longint'(lat_of(i));
            end
          end
        end
      end
      // Memory update after lookups: same-edge writes are not visible.
      if (load_en) mmem[load_addr] = load_data;
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic chk(input string name, input int i,
                     input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, i, $time, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #6;
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          chk("rst_resp_valid", i, 64'(resp_valid_o[i]), 64'(0));
          chk("rst_resp_instr", i, 64'(resp_instr_o[i]), 64'(0));
          chk("rst_resp_addr",  i, resp_addr_o[i], 64'(0));
          chk("rst_resp_fault", i, 64'(resp_fault_o[i]), 64'(0));
          chk("rst_req_ready",  i, 64'(req_ready_o[i]), 64'(!flush));
        end else begin
          chk("req_ready",  i, 64'(req_ready_o[i]), 64'(exp_ready(i)));
          chk("resp_valid", i, 64'(resp_valid_o[i]), 64'(m_rv[i]));
          if (m_rv[i]) begin
            chk("resp_instr", i, 64'(resp_instr_o[i]), 64'(m_rinstr[i]));
            chk("resp_addr",  i, resp_addr_o[i], m_raddr[i]);
            chk("resp_fault", i, 64'(resp_fault_o[i]), 64'(m_rfault[i]));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  // ---------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load_word(input int idx, input logic [31:0] d);
    load_en = 1; load_addr = 10'(idx); load_data = d;
    step();
    load_en = 0;
  endtask

  task automatic drain();
    req_valid = 0; flush = 0; resp_ready = 1;
    repeat (5) step();
  endtask

  // Single fetch with both instances idle; literal latency/data checks.
  task automatic fetch_lit(input logic [63:0] a,
                           input bit use0, input logic [31:0] i0, input bit f0,
                           input bit use1, input logic [31:0] i1, input bit f1);
    bit seen0, seen1;
    seen0 = 0; seen1 = 0;
    drain();
    req_valid = 1; req_addr = a;
    step();
    req_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (!seen0 && resp_valid_o[0]) begin
        seen0 = 1;
        chk("lit_latency", 0, 64'(k), 64'(1));
        chk("lit_addr", 0, resp_addr_o[0], a);
        if (use0) begin
          chk("lit_instr", 0, 64'(resp_instr_o[0]), 64'(i0));
          chk("lit_fault", 0, 64'(resp_fault_o[0]), 64'(f0));
        end
      end
      if (!seen1 && resp_valid_o[1]) begin
        seen1 = 1;
        chk("lit_latency", 1, 64'(k), 64'(3));
        chk("lit_addr", 1, resp_addr_o[1], a);
        if (use1) begin
          chk("lit_instr", 1, 64'(resp_instr_o[1]), 64'(i1));
          chk("lit_fault", 1, 64'(resp_fault_o[1]), 64'(f1));
        end
      end
    end
    if (!seen0) chk("lit_timeout", 0, 64'(0), 64'(1));
    if (!seen1) chk("lit_timeout", 1, 64'(0), 64'(1));
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 64'({$urandom_range(0, 1023), 2'b00});
      1: return 64'h100 + 64'({$urandom_range(0, 1023), 2'b00});
      2: return 64'($urandom_range(0, 4095));
      3: return 64'h1000 + 64'($urandom_range(0, 511));
      4: return {$urandom, $urandom};
      default: begin
        case ($urandom_range(0, 3))
          0: return 64'hFFC;
          1: return 64'h10FC;
          2: return 64'h1100;
          default: return 64'hFC;
        endcase
      end
    endcase
  endfunction

  initial begin
    logic [31:0] b2b_exp [4];
    int b2b_sent, b2b_seen;

    rst_n = 0; req_valid = 0; req_addr = '0; flush = 0; resp_ready = 0;
    load_en = 0; load_addr = '0; load_data = '0;
    repeat (2) step();
    rst_n = 1;

    // Preload whole memory, then the known program words.
    for (int k = 0; k < DEPTH; k++) load_word(k, $urandom);
    load_word(0, 32'h00500093);
    load_word(1, 32'h00a00113);
    load_word(2, 32'h002081b3);
    load_word(3, 32'h00000013);
    load_word(4, 32'h11111111);
    load_word(1023, 32'hCAFEF00D);

    // Literal data / fault / latency expectations.
    fetch_lit(64'h0,    1, 32'h00500093, 0, 1, 32'h13, 1);
    fetch_lit(64'h4,    1, 32'h00a00113, 0, 1, 32'h13, 1);
    fetch_lit(64'h6,    1, 32'h13,       1, 1, 32'h13, 1);
    fetch_lit(64'h1000, 1, 32'h13,       1, 0, 32'h0,  0);
    fetch_lit(64'hFFC,  1, 32'hCAFEF00D, 0, 0, 32'h0,  0);
    fetch_lit(64'h10FC, 1, 32'h13,       1, 1, 32'hCAFEF00D, 0);
    fetch_lit(64'h1100, 1, 32'h13,       1, 1, 32'h13, 1);
    fetch_lit(64'h108,  0, 32'h0,        0, 1, 32'h002081b3, 0);

    // Back-to-back on inst0: requests 0x0..0xC with resp_ready held high.
    drain();
    b2b_exp[0] = 32'h00500093; b2b_exp[1] = 32'h00a00113;
    b2b_exp[2] = 32'h002081b3; b2b_exp[3] = 32'h00000013;
    b2b_sent = 0; b2b_seen = 0;
    for (int n = 0; n < 30; n++) begin
      if (resp_valid_o[0] && b2b_seen < 4) begin
        chk("b2b_instr", 0, 64'(resp_instr_o[0]), 64'(b2b_exp[b2b_seen]));
        b2b_seen++;
      end
      if (b2b_sent < 4) begin
        req_valid = 1; req_addr = 64'(b2b_sent * 4);
        if (req_ready_o[0]) b2b_sent++;
      end else begin
        req_valid = 0;
      end
      step();
    end
    req_valid = 0;
    chk("b2b_count", 0, 64'(b2b_seen), 64'(4));

    // Hold response with resp_ready low; inst1 must stall with stable data.
    drain();
    resp_ready = 0; req_valid = 1; req_addr = 64'h100;
    step();
    req_valid = 0;
    repeat (5) step();
    chk("hold_valid", 1, 64'(resp_valid_o[1]), 64'(1));
    chk("hold_instr", 1, 64'(resp_instr_o[1]), 64'(32'h00500093));
    chk("hold_addr",  1, resp_addr_o[1], 64'h100);
    chk("hold_ready", 1, 64'(req_ready_o[1]), 64'(0));
    resp_ready = 1;
    step();
    chk("release_valid", 1, 64'(resp_valid_o[1]), 64'(0));
    chk("release_ready", 1, 64'(req_ready_o[1]), 64'(1));

    // Load race: word 4 rewritten on the edge the lookup happens.
    drain();
    req_valid = 1; req_addr = 64'h10;
    step();
    req_valid = 0;
    load_en = 1; load_addr = 10'd4; load_data = 32'hDEADBEEF;
    step();
    load_en = 0;
    chk("race_old_word", 0, 64'(resp_instr_o[0]), 64'(32'h11111111));
    fetch_lit(64'h10, 1, 32'hDEADBEEF, 0, 1, 32'h13, 1);

    // Flush while both are waiting: no response may ever appear.
    drain();
    req_valid = 1; req_addr = 64'h104;
    step();
    req_valid = 0; flush = 1;
    step();
    flush = 0;
    for (int n = 0; n < 6; n++) begin
      chk("flush_wait_valid", 0, 64'(resp_valid_o[0]), 64'(0));
      chk("flush_wait_valid", 1, 64'(resp_valid_o[1]), 64'(0));
      step();
    end

    // Flush alongside req_valid: never accepted.
    flush = 1; req_valid = 1; req_addr = 64'h0;
    #1;
    chk("flush_req_ready", 0, 64'(req_ready_o[0]), 64'(0));
    step();
    flush = 0; req_valid = 0;
    repeat (4) step();
    chk("flush_noaccept", 0, 64'(resp_valid_o[0]), 64'(0));

    // Reset while waiting, then a normal fetch.
    drain();
    req_valid = 1; req_addr = 64'h104;
    step();
    req_valid = 0; rst_n = 0;
    #1;
    chk("rst_mid_valid", 1, 64'(resp_valid_o[1]), 64'(0));
    chk("rst_mid_ready", 1, 64'(req_ready_o[1]), 64'(1));
    step();
    rst_n = 1;
    fetch_lit(64'h0, 1, 32'h00500093, 0, 1, 32'h13, 1);

    // Randomized traffic, checked every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 199) == 0) rst_n = 0;
      req_valid  = 1'($urandom_range(0, 1));
      req_addr   = rand_addr();
      flush      = ($urandom_range(0, 19) == 0);
      resp_ready = ($urandom_range(0, 9) < 6);
      load_en    = ($urandom_range(0, 4) == 0);
      load_addr  = 10'($urandom);
      load_data  = $urandom;
      step();
    end
    rst_n = 1; load_en = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
